// File: rtl/avalon_pio_poll_master.sv
// avalon_pio_poll_master: Avalon-MM master that periodically reads an input PIO
// and writes the value to an output PIO whenever it differs from the last value
// forwarded. Optional debounce stage enabled with AVALON_PIO_POLL_DEBOUNCE_EN.
module avalon_pio_poll_master #(
  parameter int ADDR_W       = 2,
  parameter int DATA_W       = 4,
  parameter int SRC_ADDR     = 0,
  parameter int DST_ADDR     = 0,
  parameter int POLL_PERIOD  = 1000,
  parameter int READ_LATENCY = 1,
  parameter int DEB_POLLS    = 3
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              enable,
  output logic [ADDR_W-1:0] avm_address,
  output logic              avm_read,
  output logic              avm_write,
  output logic [31:0]       avm_writedata,
  input  logic [31:0]       avm_readdata,
  input  logic              avm_waitrequest,
  output logic [DATA_W-1:0] value_o,
  output logic              changed_o,
  output logic              busy_o
);

  localparam int TMR_W = $clog2(POLL_PERIOD + 1);
  localparam int LAT_W = $clog2(READ_LATENCY + 1);
  localparam logic [TMR_W-1:0] TMR_RELOAD = TMR_W'(POLL_PERIOD - 1);
  localparam logic [LAT_W-1:0] LAT_INIT   = LAT_W'(READ_LATENCY - 1);

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_RD_REQ  = 3'd1,
    ST_RD_WAIT = 3'd2,
    ST_CMP     = 3'd3,
    ST_WR_REQ  = 3'd4
  } state_t;

  state_t            r_state;
  state_t            w_state_nxt;
  logic [TMR_W-1:0]  r_timer;
  logic [TMR_W-1:0]  w_timer_nxt;
  logic [LAT_W-1:0]  r_lat;
  logic [LAT_W-1:0]  w_lat_nxt;
  logic [DATA_W-1:0] r_sample;
  logic              r_valid;
  logic              w_fwd;
  logic              w_wr_acc;
  logic              w_capture;
  logic              w_unused;

  // Upper read-data bits and the debounce depth are not used in every build.
  assign w_unused  = &{1'b0, avm_readdata, 32'(DEB_POLLS)};
  assign w_wr_acc  = (r_state == ST_WR_REQ) && !avm_waitrequest;
  assign w_capture = (r_state == ST_RD_WAIT) && (r_lat == '0);

`ifdef AVALON_PIO_POLL_DEBOUNCE_EN
  localparam int DEB_W = $clog2(DEB_POLLS + 1);
  localparam logic [DEB_W-1:0] DEB_MAX = DEB_W'(DEB_POLLS);

  logic [DATA_W-1:0] r_cand;
  logic [DATA_W-1:0] w_cand_nxt;
  logic [DEB_W-1:0]  r_stable;
  logic [DEB_W-1:0]  w_stable_nxt;

  // Candidate/stability update implied by the current sample (saturating count).
  always_comb begin
    w_cand_nxt   = r_cand;
    w_stable_nxt = r_stable;
    if (r_sample == r_cand) begin
      if (r_stable == DEB_MAX) begin
        w_stable_nxt = r_stable;
      end else begin
        w_stable_nxt = r_stable + DEB_W'(1);
      end
    end else begin
      w_cand_nxt   = r_sample;
      w_stable_nxt = DEB_W'(1);
    end
  end

  assign w_fwd = (w_stable_nxt == DEB_MAX) && (!r_valid || (w_cand_nxt != value_o));

  // Stability tracking advances once per poll, in the compare cycle.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_cand   <= '0;
      r_stable <= '0;
    end else if (r_state == ST_CMP) begin
      r_cand   <= w_cand_nxt;
      r_stable <= w_stable_nxt;
    end
  end
`else
  assign w_fwd = !r_valid || (r_sample != value_o);
`endif

  // Next-state, poll timer and read-latency counter.
  always_comb begin
    w_state_nxt = r_state;
    w_timer_nxt = r_timer;
    w_lat_nxt   = r_lat;
    case (r_state)
      ST_IDLE: begin
        if (!enable) begin
          w_timer_nxt = r_timer;
        end else if (r_timer == '0) begin
          w_state_nxt = ST_RD_REQ;
          w_timer_nxt = TMR_RELOAD;
        end else begin
          w_timer_nxt = r_timer - TMR_W'(1);
        end
      end
      ST_RD_REQ: begin
        if (!avm_waitrequest) begin
          w_state_nxt = ST_RD_WAIT;
          w_lat_nxt   = LAT_INIT;
        end else begin
          w_state_nxt = ST_RD_REQ;
        end
      end
      ST_RD_WAIT: begin
        if (r_lat == '0) begin
          w_state_nxt = ST_CMP;
        end else begin
          w_lat_nxt = r_lat - LAT_W'(1);
        end
      end
      ST_CMP: begin
        if (w_fwd) begin
          w_state_nxt = ST_WR_REQ;
        end else begin
          w_state_nxt = ST_IDLE;
        end
      end
      ST_WR_REQ: begin
        if (!avm_waitrequest) begin
          w_state_nxt = ST_IDLE;
        end else begin
          w_state_nxt = ST_WR_REQ;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  // State, timer and latency counter registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= ST_IDLE;
      r_timer <= TMR_RELOAD;
      r_lat   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_timer <= w_timer_nxt;
      r_lat   <= w_lat_nxt;
    end
  end

  // Sample capture on the read-data-valid cycle; forwarded value on write accept.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_sample  <= '0;
      r_valid   <= 1'b0;
      value_o   <= '0;
      changed_o <= 1'b0;
    end else begin
      if (w_capture) begin
        r_sample <= avm_readdata[DATA_W-1:0];
      end
      changed_o <= w_wr_acc;
      if (w_wr_acc) begin
        value_o <= r_sample;
        r_valid <= 1'b1;
      end
    end
  end

  // Bus outputs registered from the next state so they track it cycle-exactly.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      avm_read      <= 1'b0;
      avm_write     <= 1'b0;
      avm_address   <= '0;
      avm_writedata <= 32'd0;
      busy_o        <= 1'b0;
    end else begin
      avm_read      <= (w_state_nxt == ST_RD_REQ);
      avm_write     <= (w_state_nxt == ST_WR_REQ);
      avm_writedata <= (w_state_nxt == ST_WR_REQ) ? 32'(r_sample) : 32'd0;
      busy_o        <= (w_state_nxt != ST_IDLE);
      case (w_state_nxt)
        ST_RD_REQ: avm_address <= ADDR_W'(SRC_ADDR);
        ST_WR_REQ: avm_address <= ADDR_W'(DST_ADDR);
        default:   avm_address <= '0;
      endcase
    end
  end

endmodule

// File: tb/tb_avalon_pio_poll_master.sv
// Self-checking bench for avalon_pio_poll_master: fixed-latency slave model,
// poll-level reference model feeding an expected-write queue, bus monitor.
module tb_avalon_pio_poll_master;

  localparam int ADDR_W = 2;
  localparam int DATA_W = 4;
  localparam int SRC_A  = 1;
  localparam int DST_A  = 2;
  localparam int PERIOD = 4;
  localparam int RD_LAT = 2;
  localparam int DEB    = 3;
  localparam logic [31:0] DMASK = 32'((64'd1 << DATA_W) - 64'd1);

  logic              clk;
  logic              reset_n;
  logic              enable;
  logic [ADDR_W-1:0] avm_address;
  logic              avm_read;
  logic              avm_write;
  logic [31:0]       avm_writedata;
  logic [31:0]       avm_readdata;
  logic              avm_waitrequest;
  logic [DATA_W-1:0] value_o;
  logic              changed_o;
  logic              busy_o;

  avalon_pio_poll_master #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .SRC_ADDR(SRC_A), .DST_ADDR(DST_A),
    .POLL_PERIOD(PERIOD), .READ_LATENCY(RD_LAT), .DEB_POLLS(DEB)
  ) dut (
    .clk(clk), .reset_n(reset_n), .enable(enable),
    .avm_address(avm_address), .avm_read(avm_read), .avm_write(avm_write),
    .avm_writedata(avm_writedata), .avm_readdata(avm_readdata),
    .avm_waitrequest(avm_waitrequest), .value_o(value_o),
    .changed_o(changed_o), .busy_o(busy_o)
  );

  initial clk = 1'b0;
  always #10 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  int n_reads  = 0;
  int n_writes = 0;
  int n_exp    = 0;

  // stimulus knobs
  logic [DATA_W-1:0] in_val;
  logic [DATA_W-1:0] poll_q[$];
  int rd_stall;
  int wr_stall;
  bit rand_stall;

  // reference model state
  logic [DATA_W-1:0] exp_q[$];
  logic [DATA_W-1:0] m_last;
  bit                m_valid;
`ifdef AVALON_PIO_POLL_DEBOUNCE_EN
  logic [DATA_W-1:0] m_cand;
  int                m_stable;
`endif

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic model_reset();
    n_exp -= exp_q.size();
    exp_q.delete();
    m_valid = 1'b0;
    m_last  = '0;
`ifdef AVALON_PIO_POLL_DEBOUNCE_EN
    m_cand   = '0;
    m_stable = 0;
`endif
  endtask

  // One poll observed: decide whether a forwarding write must follow.
  task automatic model_poll(input logic [DATA_W-1:0] s);
`ifdef AVALON_PIO_POLL_DEBOUNCE_EN
    if (s == m_cand) begin
      if (m_stable < DEB) m_stable++;
    end else begin
      m_cand   = s;
      m_stable = 1;
    end
    if (m_stable == DEB && (!m_valid || m_cand != m_last)) begin
      exp_q.push_back(m_cand);
      m_last  = m_cand;
      m_valid = 1'b1;
      n_exp++;
    end
`else
    if (!m_valid || s != m_last) begin
      exp_q.push_back(s);
      m_last  = s;
      m_valid = 1'b1;
      n_exp++;
    end
`endif
  endtask

  function automatic int pick_stall(input int fixed);
    if (rand_stall) return int'($urandom_range(0, 3));
    return fixed;
  endfunction

  // Slave: drives waitrequest/readdata on the falling edge, fixed read latency.
  initial begin : slave
    int cd;
    int stall_left;
    bit in_req;
    logic [DATA_W-1:0] rd_val;
    cd = 0; stall_left = 0; in_req = 0; rd_val = '0;
    avm_waitrequest = 1'b0;
    avm_readdata = 32'd0;
    forever begin
      @(negedge clk);
      avm_readdata = $urandom();
      if (!reset_n) begin
        cd = 0; in_req = 0;
        avm_waitrequest = 1'b0;
        model_reset();
      end else begin
        if (cd > 0) begin
          cd--;
          if (cd == 0) avm_readdata = (avm_readdata & ~DMASK) | 32'(rd_val);
        end
        if (avm_read || avm_write) begin
          if (!in_req) begin
            in_req = 1;
            stall_left = avm_read ? pick_stall(rd_stall) : pick_stall(wr_stall);
          end
          if (stall_left > 0) begin
            avm_waitrequest = 1'b1;
            stall_left--;
          end else begin
            avm_waitrequest = 1'b0;
            in_req = 0;
            if (avm_read) begin
              if (poll_q.size() > 0) rd_val = poll_q.pop_front();
              else rd_val = in_val;
              model_poll(rd_val);
              cd = RD_LAT;
            end
          end
        end else begin
          in_req = 0;
          avm_waitrequest = 1'($urandom_range(0, 1));
        end
      end
    end
  end

  // Monitor: protocol rules and scoreboard comparison of every accepted write.
  initial begin : monitor
    bit prev_stall;
    bit prev_wacc;
    logic [DATA_W-1:0] prev_wval;
    logic [35:0] prev_sig;
    logic [ADDR_W-1:0] exp_addr;
    logic [DATA_W-1:0] e;
    bit wacc;
    prev_stall = 0; prev_wacc = 0; prev_wval = '0; prev_sig = '0;
    forever begin
      @(negedge clk);
      #2;
      if (!reset_n) begin
        chk("reset_outputs", {avm_read, avm_write, changed_o, busy_o, value_o,
                              avm_address, avm_writedata}, 64'd0);
        prev_stall = 0; prev_wacc = 0;
      end else begin
        chk("rw_exclusive", avm_read & avm_write, 64'd0);
        exp_addr = avm_read ? ADDR_W'(SRC_A) : (avm_write ? ADDR_W'(DST_A) : '0);
        chk("address", avm_address, exp_addr);
        if (avm_read || avm_write) chk("busy_during_req", busy_o, 64'd1);
        if (prev_stall)
          chk("stall_stable", {avm_read, avm_write, avm_address, avm_writedata}, prev_sig);
        chk("changed_pulse", changed_o, prev_wacc);
        if (prev_wacc) chk("value_o_after_write", value_o, prev_wval);
        if (avm_read && !avm_waitrequest) n_reads++;
        wacc = avm_write && !avm_waitrequest;
        if (wacc) begin
          n_writes++;
          chk("write_expected", exp_q.size() != 0, 64'd1);
          if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            chk("write_data", avm_writedata, 32'(e));
            prev_wval = e;
          end
        end
        prev_wacc  = wacc;
        prev_stall = (avm_read || avm_write) && avm_waitrequest;
        prev_sig   = {avm_read, avm_write, avm_address, avm_writedata};
      end
    end
  end

  task automatic tick();
    @(negedge clk);
    #5;
  endtask

  task automatic wait_reads(input int target, input int budget);
    int c;
    c = 0;
    while (n_reads < target && c < budget) begin tick(); c++; end
    chk("read_wait", n_reads >= target, 64'd1);
  endtask

  task automatic wait_writes(input int target, input int budget);
    int c;
    c = 0;
    while (n_writes < target && c < budget) begin tick(); c++; end
    chk("write_wait", n_writes >= target, 64'd1);
    tick(); tick();
  endtask

  // Directed scenarios followed by a randomized phase.
  initial begin : main
    int first;
    int r0;
    int w0;
    int c;
    reset_n = 1'b0; enable = 1'b0; in_val = 4'h5;
    rd_stall = 0; wr_stall = 0; rand_stall = 0;
    m_valid = 1'b0; m_last = '0;
`ifdef AVALON_PIO_POLL_DEBOUNCE_EN
    m_cand = '0; m_stable = 0;
`endif
    repeat (3) tick();
    enable = 1'b1;
    tick();
    reset_n = 1'b1;

    // T1: first read exactly POLL_PERIOD edges after release, then a write of 5
    first = 0;
    for (int i = 1; i <= 10; i++) begin
      @(posedge clk); #1;
      if (first == 0 && avm_read) first = i;
    end
    chk("t1_first_read_cycle", first, 64'd4);
    wait_writes(1, 300);
    chk("t1_value", value_o, 64'h5);

    // T2: stable input -> reads only
    r0 = n_reads; w0 = n_writes;
    wait_reads(r0 + 3, 200);
    repeat (5) tick();
    chk("t2_reads", n_reads, 64'(r0 + 3));
    chk("t2_writes", n_writes, 64'(w0));

    // T3: stalls on both transactions, 5 -> A
    rd_stall = 3; wr_stall = 2; in_val = 4'hA;
    w0 = n_writes;
    wait_writes(w0 + 1, 400);
    r0 = n_reads;
    wait_reads(r0 + 2, 200);
    repeat (5) tick();
    chk("t3_single_write", n_writes, 64'(w0 + 1));
    chk("t3_value", value_o, 64'hA);

    // T4: asynchronous reset while a write is stalled on the bus
    rd_stall = 0; wr_stall = 4; in_val = 4'h3;
    c = 0;
    while (!avm_write && c < 400) begin tick(); c++; end
    chk("t4_write_seen", avm_write, 64'd1);
    #1 reset_n = 1'b0;
    #1 chk("t4_write_drop", {avm_write, avm_read}, 64'd0);
    tick(); tick();
    wr_stall = 0; in_val = 4'hA;
    reset_n = 1'b1;
    w0 = n_writes;
    wait_writes(w0 + 1, 400);
    chk("t4_rewrite", n_writes, 64'(w0 + 1));
    chk("t4_value", value_o, 64'hA);

    // T5: enable dropped while waiting for read data
    in_val = 4'h6;
    r0 = n_reads;
    wait_reads(r0 + 1, 200);
    tick();
    enable = 1'b0;
    repeat (40) tick();
    chk("t5_no_more_reads", n_reads, 64'(r0 + 1));
    chk("t5_write_done", n_writes, 64'(n_exp));
    chk("t5_parked", busy_o, 64'd0);
    enable = 1'b1;
    wait_reads(r0 + 2, 200);
    chk("t5_resumed", n_reads, 64'(r0 + 2));

    // T6: sequence 1,2,2,2 from a settled value of C
    in_val = 4'hC;
    c = 0;
    while (value_o != 4'hC && c < 500) begin tick(); c++; end
    chk("t6_settled", value_o, 64'hC);
    repeat (12) tick();
    w0 = n_writes; r0 = n_reads;
    poll_q.push_back(4'h1); poll_q.push_back(4'h2);
    poll_q.push_back(4'h2); poll_q.push_back(4'h2);
    in_val = 4'h2;
    wait_reads(r0 + 4, 300);
    repeat (8) tick();
`ifdef AVALON_PIO_POLL_DEBOUNCE_EN
    chk("t6_writes", n_writes, 64'(w0 + 1));
`else
    chk("t6_writes", n_writes, 64'(w0 + 2));
`endif
    chk("t6_value", value_o, 64'h2);

    // Randomized phase: random stalls, input changes and enable toggles
    rand_stall = 1;
    for (int i = 0; i < 800; i++) begin
      tick();
      if ($urandom_range(0, 19) == 0) in_val = DATA_W'($urandom());
      if ($urandom_range(0, 59) == 0) enable = ~enable;
    end
    enable = 1'b1;
    repeat (40) tick();
    enable = 1'b0;
    repeat (60) tick();
    chk("final_queue_empty", exp_q.size(), 64'd0);
    chk("final_write_count", n_writes, 64'(n_exp));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
